fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_drain.sv | 87 ++++++++
 tb/tb_fifo_drain.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// +--------------------------------------------------------------------+
// | fifo_pkg : shared widths, keep encodings and drain FSM state type   |
// | Rev 1.0  : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [1:0] KEEP_FULL = 2'b11;
  localparam logic [1:0] KEEP_ODD  = 2'b01;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_drain.sv
// +--------------------------------------------------------------------+
// | fifo_drain : pops bytes from a sync FIFO and packs them into words  |
// | Rev 1.0    : initial release                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module fifo_drain
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [BYTE_W-1:0] fifo_dout,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic [1:0]        m_keep,
  output logic              busy
);

  drain_state_t      r_state;
  logic              r_pend;
  logic              r_lo_vld;
  logic [BYTE_W-1:0] r_lo_byte;

  logic       w_out_free;
  logic [1:0] w_occ;
  logic       w_pop_ok;
  logic       w_pair;
  logic       w_flush_done;

  assign w_out_free = !m_valid || m_ready;
  assign w_occ      = {1'b0, r_lo_vld} + {1'b0, r_pend};

  // A second byte is only requested when the output register will have room
  // by the time both bytes are present, so a pair never finds it occupied.
  assign w_pop_ok     = !fifo_empty && (w_occ < 2'd2) && ((w_occ == 2'd0) || w_out_free);
  assign fifo_rd_en   = reset_n && (r_state == ST_RUN) && w_pop_ok;
  assign w_pair       = r_pend && r_lo_vld;
  assign w_flush_done = (r_state == ST_FLUSH) && !r_pend && w_out_free;
  assign busy         = r_pend || r_lo_vld || m_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_RUN;
      r_pend    <= 1'b0;
      r_lo_vld  <= 1'b0;
      r_lo_byte <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_keep    <= 2'b00;
    end else begin
      r_pend <= fifo_rd_en && !fifo_empty;

      if (w_pair) begin
        m_data   <= {fifo_dout, r_lo_byte};
        m_keep   <= KEEP_FULL;
        m_valid  <= 1'b1;
        r_lo_vld <= 1'b0;
      end else if (w_flush_done && r_lo_vld) begin
        m_data   <= {{BYTE_W{1'b0}}, r_lo_byte};
        m_keep   <= KEEP_ODD;
        m_valid  <= 1'b1;
        r_lo_vld <= 1'b0;
      end else begin
        if (m_valid && m_ready) begin
          m_valid <= 1'b0;
        end
        if (r_pend && !r_lo_vld) begin
          r_lo_byte <= fifo_dout;
          r_lo_vld  <= 1'b1;
        end
      end

      case (r_state)
        ST_RUN:   if (flush) r_state <= ST_FLUSH;
        ST_FLUSH: if (w_flush_done) r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain.sv
// +--------------------------------------------------------------------+
// | tb_fifo_drain : directed bench, behavioural 16x8 FIFO feeding DUT   |
// | Rev 1.0       : initial release                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fifo_drain;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout;
  logic        flush;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [1:0]  m_keep;
  logic        busy;

  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  mem [16];
  logic [3:0]  wp;
  logic [3:0]  rp;
  logic [4:0]  cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fifo_drain dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .busy       (busy)
  );

  // Upstream 16x8 synchronous FIFO: read data appears the cycle after a pop.
  assign fifo_empty = (cnt == 5'd0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      fifo_dout <= '0;
    end else begin
      if (wr_en && cnt < 5'd16) begin
        mem[wp] <= wr_data;
        wp      <= wp + 4'd1;
      end
      if (fifo_rd_en && cnt != 5'd0) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 4'd1;
      end
      cnt <= cnt + 5'((wr_en && cnt < 5'd16) ? 1 : 0) - 5'((fifo_rd_en && cnt != 5'd0) ? 1 : 0);
    end
  end

  int          cyc = 0;
  logic [17:0] out_q [$];
  int          out_cyc [$];
  int          pop_cyc [$];
  int          stab_err = 0;
  logic        hold_prev = 1'b0;
  logic [15:0] prev_d = '0;
  logic [1:0]  prev_k = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && !fifo_empty) pop_cyc.push_back(cyc);
    if (m_valid && m_ready) begin
      out_q.push_back({m_keep, m_data});
      out_cyc.push_back(cyc);
    end
    if (reset_n && hold_prev && (!m_valid || m_data !== prev_d || m_keep !== prev_k))
      stab_err <= stab_err + 1;
    hold_prev <= reset_n && m_valid && !m_ready;
    prev_d    <= m_data;
    prev_k    <= m_keep;
  end

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    while (cnt == 5'd16 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int idle = 0;
    for (int k = 0; k < 3000 && idle < 4; k++) begin
      @(negedge clk);
      if (!busy && fifo_empty) idle++;
      else idle = 0;
    end
    tests_run++;
    if (idle < 4) begin
      tests_failed++;
      $display("FAIL %s_idle_timeout: busy=%0b empty=%0b required idle", name, busy, fifo_empty);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    flush   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %0b want 0", fifo_rd_en); end
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
    tests_run++; if (m_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_m_data: got %h want 0000", m_data); end
    tests_run++; if (m_keep !== 2'b00) begin tests_failed++; $display("FAIL reset_m_keep: got %b want 00", m_keep); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pairs();
    int o0;
    m_ready = 1'b1;
    o0 = out_q.size();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_idle("pairs");
    tests_run++;
    if (out_q.size() - o0 != 2) begin
      tests_failed++;
      $display("FAIL pairs_count: got %0d words want 2", out_q.size() - o0);
    end else begin
      tests_run++; if (out_q[o0] !== {2'b11, 16'h2211}) begin tests_failed++; $display("FAIL pairs_word0: got %h want %h", out_q[o0], {2'b11, 16'h2211}); end
      tests_run++; if (out_q[o0+1] !== {2'b11, 16'h4433}) begin tests_failed++; $display("FAIL pairs_word1: got %h want %h", out_q[o0+1], {2'b11, 16'h4433}); end
    end
  endtask

  task automatic test_throughput();
    int o0, p0;
    m_ready = 1'b1;
    o0 = out_q.size();
    p0 = pop_cyc.size();
    for (int i = 0; i < 6; i++) push_byte(8'(8'h60 + i));
    wait_idle("thru");
    tests_run++;
    if (out_q.size() - o0 != 3 || pop_cyc.size() - p0 < 1) begin
      tests_failed++;
      $display("FAIL thru_count: got %0d words want 3", out_q.size() - o0);
    end else begin
      tests_run++; if (out_cyc[o0] - pop_cyc[p0] != 3) begin tests_failed++; $display("FAIL thru_first_latency: got %0d want 3", out_cyc[o0] - pop_cyc[p0]); end
      tests_run++; if (out_cyc[o0+1] - out_cyc[o0] != 3) begin tests_failed++; $display("FAIL thru_gap1: got %0d want 3", out_cyc[o0+1] - out_cyc[o0]); end
      tests_run++; if (out_cyc[o0+2] - out_cyc[o0+1] != 3) begin tests_failed++; $display("FAIL thru_gap2: got %0d want 3", out_cyc[o0+2] - out_cyc[o0+1]); end
      tests_run++; if (out_q[o0+2] !== {2'b11, 16'h6564}) begin tests_failed++; $display("FAIL thru_word2: got %h want %h", out_q[o0+2], {2'b11, 16'h6564}); end
    end
  endtask

  task automatic test_flush_odd();
    int o0;
    m_ready = 1'b1;
    o0 = out_q.size();
    push_byte(8'hA5);
    repeat (4) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL odd_held_busy: got %0b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle("odd");
    tests_run++;
    if (out_q.size() - o0 != 1) begin
      tests_failed++;
      $display("FAIL odd_count: got %0d words want 1", out_q.size() - o0);
    end else begin
      tests_run++; if (out_q[o0] !== {2'b01, 16'h00A5}) begin tests_failed++; $display("FAIL odd_word: got %h want %h", out_q[o0], {2'b01, 16'h00A5}); end
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL odd_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_flush_inflight();
    int o0;
    m_ready = 1'b1;
    o0 = out_q.size();
    push_byte(8'h01);
    push_byte(8'h02);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle("inflight");
    tests_run++;
    if (out_q.size() - o0 != 1) begin
      tests_failed++;
      $display("FAIL inflight_count: got %0d words want 1", out_q.size() - o0);
    end else begin
      tests_run++; if (out_q[o0] !== {2'b11, 16'h0201}) begin tests_failed++; $display("FAIL inflight_word: got %h want %h", out_q[o0], {2'b11, 16'h0201}); end
    end
  endtask

  task automatic test_backpressure();
    int o0, s0, bad;
    m_ready = 1'b0;
    o0 = out_q.size();
    s0 = stab_err;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    repeat (6) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(m_valid === 1'b1 && m_data === 16'h1110 && m_keep === 2'b11 && fifo_rd_en === 1'b0)) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    tests_run++; if (cnt !== 5'd13) begin tests_failed++; $display("FAIL bp_fifo_level: got %0d want 13", cnt); end
    m_ready = 1'b1;
    wait_idle("bp");
    tests_run++;
    if (out_q.size() - o0 != 8) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d words want 8", out_q.size() - o0);
    end else begin
      for (int w = 0; w < 8; w++) begin
        logic [7:0] lo, hi;
        lo = 8'(8'h10 + 2*w);
        hi = 8'(8'h11 + 2*w);
        tests_run++;
        if (out_q[o0+w] !== {2'b11, hi, lo}) begin
          tests_failed++;
          $display("FAIL bp_word%0d: got %h want %h", w, out_q[o0+w], {2'b11, hi, lo});
        end
      end
    end
    tests_run++; if (stab_err != s0) begin tests_failed++; $display("FAIL bp_stable: got %0d changes want 0", stab_err - s0); end
  endtask

  task automatic test_reset_mid();
    int o0;
    m_ready = 1'b0;
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
    repeat (10) @(negedge clk);
    tests_run++; if (m_valid !== 1'b1 || m_data !== 16'hC2C1) begin tests_failed++; $display("FAIL rmid_pre: got v=%0b d=%h want v=1 d=c2c1", m_valid, m_data); end
    reset_n = 1'b0;
    #1;
    tests_run++; if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_m_valid: got %0b want 0", m_valid); end
    tests_run++; if (m_data !== 16'h0000) begin tests_failed++; $display("FAIL rmid_m_data: got %h want 0000", m_data); end
    tests_run++; if (m_keep !== 2'b00) begin tests_failed++; $display("FAIL rmid_m_keep: got %b want 00", m_keep); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL rmid_rd_en: got %0b want 0", fifo_rd_en); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_ready = 1'b1;
    o0 = out_q.size();
    push_byte(8'hBE); push_byte(8'hEF);
    wait_idle("rmid");
    tests_run++;
    if (out_q.size() - o0 != 1) begin
      tests_failed++;
      $display("FAIL rmid_count: got %0d words want 1", out_q.size() - o0);
    end else begin
      tests_run++; if (out_q[o0] !== {2'b11, 16'hEFBE}) begin tests_failed++; $display("FAIL rmid_word: got %h want %h", out_q[o0], {2'b11, 16'hEFBE}); end
    end
  endtask

  task automatic test_random();
    int o0, s0, idx, errs;
    o0 = out_q.size();
    s0 = stab_err;
    idx = 0;
    for (int k = 0; k < 5000 && idx < 256; k++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (cnt < 5'd16) begin
        wr_en   = 1'b1;
        wr_data = 8'(idx) ^ 8'h5A;
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    for (int k = 0; k < 400; k++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_idle("rand");
    tests_run++;
    if (out_q.size() - o0 != 128) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d words want 128", out_q.size() - o0);
    end else begin
      errs = 0;
      for (int w = 0; w < 128; w++) begin
        logic [7:0] lo, hi;
        lo = 8'(2*w) ^ 8'h5A;
        hi = 8'(2*w + 1) ^ 8'h5A;
        tests_run++;
        if (out_q[o0+w] !== {2'b11, hi, lo}) begin
          tests_failed++;
          errs++;
          if (errs <= 8) $display("FAIL rand_word%0d: got %h want %h", w, out_q[o0+w], {2'b11, hi, lo});
        end
      end
    end
    tests_run++; if (stab_err != s0) begin tests_failed++; $display("FAIL rand_stable: got %0d changes want 0", stab_err - s0); end
  endtask

  initial begin
    test_reset();
    test_pairs();
    test_throughput();
    test_flush_odd();
    test_flush_inflight();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
